// File: rtl/systolic_matmul.sv
// systolic_matmul: output-stationary A_ROWS x B_COLS systolic array
// that streams K_DIM beats of A columns / B rows and returns C = A*B.
module systolic_matmul #(
  parameter int DATA_WIDTH = 8,
  parameter int A_ROWS     = 2,
  parameter int B_COLS     = 2,
  parameter int K_DIM      = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a [A_ROWS],
  input  logic [DATA_WIDTH-1:0] b [B_COLS],
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  c [A_ROWS][B_COLS]
);

  localparam int DRAIN_LEN = A_ROWS + B_COLS - 2;
  localparam int KW  = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam int DCW = $clog2(DRAIN_LEN + 1) + 1;
  localparam int PW  = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k_cnt;
  logic [DCW-1:0]  d_cnt;
  logic            take;
  logic            clr;
  logic            run;

  logic [DATA_WIDTH-1:0] a_inj  [A_ROWS];
  logic [DATA_WIDTH-1:0] b_inj  [B_COLS];
  logic [DATA_WIDTH-1:0] a_row  [A_ROWS];
  logic [DATA_WIDTH-1:0] b_col  [B_COLS];
  logic [DATA_WIDTH-1:0] a_skew [A_ROWS][A_ROWS];
  logic [DATA_WIDTH-1:0] b_skew [B_COLS][B_COLS];
  logic [DATA_WIDTH-1:0] a_pipe [A_ROWS][B_COLS];
  logic [DATA_WIDTH-1:0] b_pipe [A_ROWS][B_COLS];
  logic [DATA_WIDTH-1:0] a_in   [A_ROWS][B_COLS];
  logic [DATA_WIDTH-1:0] b_in   [A_ROWS][B_COLS];

  assign take = in_valid && in_ready;
  assign clr  = start && (state == IDLE || state == DONE);
  assign run  = (state == LOAD) || (state == DRAIN);

  // Full-width product, sign- or zero-extended to the accumulator
  function automatic logic [ACC_WIDTH-1:0] mul(
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] y
  );
    logic signed [PW-1:0] sp;
    logic        [PW-1:0] up;
    sp = $signed({{DATA_WIDTH{x[DATA_WIDTH-1]}}, x})
       * $signed({{DATA_WIDTH{y[DATA_WIDTH-1]}}, y});
    up = {{DATA_WIDTH{1'b0}}, x} * {{DATA_WIDTH{1'b0}}, y};
    if (SIGNED != 0) mul = ACC_WIDTH'(sp);
    else             mul = ACC_WIDTH'(up);
  endfunction

  // Stalled cycles feed zeros so they never disturb C; rows and
  // columns then see their skewed operand and the neighbour's copy.
  for (genvar i = 0; i < A_ROWS; i++) begin : g_arow
    assign a_inj[i] = take ? a[i] : '0;
    if (i == 0) begin : g_nd
      assign a_row[i] = a_inj[i];
    end else begin : g_d
      assign a_row[i] = a_skew[i][i-1];
    end
    for (genvar j = 0; j < B_COLS; j++) begin : g_ain
      if (j == 0) begin : g_e
        assign a_in[i][j] = a_row[i];
      end else begin : g_p
        assign a_in[i][j] = a_pipe[i][j-1];
      end
    end
  end

  for (genvar j = 0; j < B_COLS; j++) begin : g_bcol
    assign b_inj[j] = take ? b[j] : '0;
    if (j == 0) begin : g_nd
      assign b_col[j] = b_inj[j];
    end else begin : g_d
      assign b_col[j] = b_skew[j][j-1];
    end
    for (genvar i = 0; i < A_ROWS; i++) begin : g_bin
      if (i == 0) begin : g_e
        assign b_in[i][j] = b_col[j];
      end else begin : g_p
        assign b_in[i][j] = b_pipe[i-1][j];
      end
    end
  end

  // Control: job sequencing, beat and drain counting, registered flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      k_cnt    <= '0;
      d_cnt    <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state    <= LOAD;
            k_cnt    <= '0;
            d_cnt    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (take) begin
            if (k_cnt == KW'(K_DIM - 1)) begin
              in_ready <= 1'b0;
              if (DRAIN_LEN == 0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= DRAIN;
                d_cnt <= '0;
              end
            end else begin
              k_cnt <= k_cnt + KW'(1);
            end
          end
        end
        DRAIN: begin
          if (d_cnt == DCW'(DRAIN_LEN - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            d_cnt <= d_cnt + DCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: skew lines, PE operand hand-off and accumulation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < A_ROWS; i++) begin
        for (int d = 0; d < A_ROWS; d++) a_skew[i][d] <= '0;
        for (int j = 0; j < B_COLS; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
          c[i][j]      <= '0;
        end
      end
      for (int j = 0; j < B_COLS; j++)
        for (int d = 0; d < B_COLS; d++) b_skew[j][d] <= '0;
    end else if (clr) begin
      for (int i = 0; i < A_ROWS; i++) begin
        for (int d = 0; d < A_ROWS; d++) a_skew[i][d] <= '0;
        for (int j = 0; j < B_COLS; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
          c[i][j]      <= '0;
        end
      end
      for (int j = 0; j < B_COLS; j++)
        for (int d = 0; d < B_COLS; d++) b_skew[j][d] <= '0;
    end else if (run) begin
      for (int i = 0; i < A_ROWS; i++) begin
        a_skew[i][0] <= a_inj[i];
        for (int d = 1; d < A_ROWS; d++) a_skew[i][d] <= a_skew[i][d-1];
      end
      for (int j = 0; j < B_COLS; j++) begin
        b_skew[j][0] <= b_inj[j];
        for (int d = 1; d < B_COLS; d++) b_skew[j][d] <= b_skew[j][d-1];
      end
      for (int i = 0; i < A_ROWS; i++) begin
        for (int j = 0; j < B_COLS; j++) begin
          a_pipe[i][j] <= a_in[i][j];
          b_pipe[i][j] <= b_in[i][j];
          c[i][j]      <= c[i][j] + mul(a_in[i][j], b_in[i][j]);
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul.sv
// tb_systolic_matmul: random and directed jobs on three configurations,
// checked every cycle against a matrix-level reference model.
module tb_systolic_matmul;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        st0, v0, rdy0, busy0, done0;
  logic [7:0]  a0 [2];
  logic [7:0]  b0 [2];
  logic [19:0] c0 [2][2];

  logic        st1, v1;
  logic [7:0]  a1 [2];
  logic [7:0]  b1 [2];
  logic        rdy1, busy1, done1;
  logic [19:0] c1 [2][2];
  logic        rdy2, busy2, done2;
  logic [15:0] c2 [2][2];

  systolic_matmul u0 (
    .clk(clk), .reset(reset), .start(st0), .in_valid(v0),
    .in_ready(rdy0), .a(a0), .b(b0), .busy(busy0), .done(done0), .c(c0)
  );

  systolic_matmul #(.K_DIM(2), .SIGNED(1)) u1 (
    .clk(clk), .reset(reset), .start(st1), .in_valid(v1),
    .in_ready(rdy1), .a(a1), .b(b1), .busy(busy1), .done(done1), .c(c1)
  );

  systolic_matmul #(.K_DIM(2), .ACC_WIDTH(16)) u2 (
    .clk(clk), .reset(reset), .start(st1), .in_valid(v1),
    .in_ready(rdy2), .a(a1), .b(b1), .busy(busy2), .done(done2), .c(c2)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // reference model: job phase per group, captured A/B, expected C
  int          ph [2] = '{0, 0};
  int          kk [2] = '{0, 0};
  int          dd [2] = '{0, 0};
  logic [7:0]  mA [2][2][4];
  logic [7:0]  mB [2][4][2];
  logic [19:0] ec0 [2][2];
  logic [19:0] ec1 [2][2];
  logic [15:0] ec2 [2][2];
  logic        ms, mv;
  int          mk;

  task automatic result(input int g);
    longint su, ss;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        su = 0;
        ss = 0;
        for (int k = 0; k < ((g == 0) ? 4 : 2); k++) begin
          su += longint'(mA[g][i][k]) * longint'(mB[g][k][j]);
          ss += longint'($signed(mA[g][i][k]))
              * longint'($signed(mB[g][k][j]));
        end
        if (g == 0) ec0[i][j] = su[19:0];
        else begin
          ec1[i][j] = ss[19:0];
          ec2[i][j] = su[15:0];
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < 2; g++) begin
        ph[g] = P_IDLE;
        kk[g] = 0;
        dd[g] = 0;
      end
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          ec0[i][j] = '0;
          ec1[i][j] = '0;
          ec2[i][j] = '0;
        end
    end else begin
      for (int g = 0; g < 2; g++) begin
        ms = (g == 0) ? st0 : st1;
        mv = (g == 0) ? v0 : v1;
        mk = (g == 0) ? 4 : 2;
        case (ph[g])
          P_IDLE, P_DONE: begin
            if (ms) begin
              ph[g] = P_LOAD;
              kk[g] = 0;
            end else ph[g] = P_IDLE;
          end
          P_LOAD: begin
            if (mv) begin
              for (int i = 0; i < 2; i++)
                mA[g][i][kk[g]] = (g == 0) ? a0[i] : a1[i];
              for (int j = 0; j < 2; j++)
                mB[g][kk[g]][j] = (g == 0) ? b0[j] : b1[j];
              if (kk[g] == mk - 1) begin
                ph[g] = P_DRAIN;
                dd[g] = 0;
              end else kk[g]++;
            end
          end
          P_DRAIN: begin
            dd[g]++;
            if (dd[g] == 2) begin
              ph[g] = P_DONE;
              result(g);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 2; g++) begin
        logic eb, er, ed, cv;
        eb = (ph[g] == P_LOAD) || (ph[g] == P_DRAIN);
        er = (ph[g] == P_LOAD);
        ed = (ph[g] == P_DONE);
        cv = (ph[g] == P_IDLE) || (ph[g] == P_DONE);
        if (g == 0) begin
          chk("busy0", busy0, eb);
          chk("ready0", rdy0, er);
          chk("done0", done0, ed);
        end else begin
          chk("busy1", busy1, eb);
          chk("ready1", rdy1, er);
          chk("done1", done1, ed);
          chk("busy2", busy2, eb);
          chk("ready2", rdy2, er);
          chk("done2", done2, ed);
        end
        if (cv) begin
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
              if (g == 0)
                chk($sformatf("c0[%0d][%0d]", i, j), c0[i][j], ec0[i][j]);
              else begin
                chk($sformatf("c1[%0d][%0d]", i, j), c1[i][j], ec1[i][j]);
                chk($sformatf("c2[%0d][%0d]", i, j), c2[i][j], ec2[i][j]);
              end
            end
        end
      end
    end
  end

  logic [7:0] tA [2][4];
  logic [7:0] tB [4][2];

  task automatic drive(input int g, input logic s, input logic v,
                       input logic [7:0] x0, input logic [7:0] x1,
                       input logic [7:0] y0, input logic [7:0] y1);
    if (g == 0) begin
      st0 = s; v0 = v;
      a0[0] = x0; a0[1] = x1; b0[0] = y0; b0[1] = y1;
    end else begin
      st1 = s; v1 = v;
      a1[0] = x0; a1[1] = x1; b1[0] = y0; b1[1] = y1;
    end
  endtask

  task automatic drive_idle(input int g, input logic s);
    drive(g, s, 1'b0, 8'($urandom), 8'($urandom),
          8'($urandom), 8'($urandom));
  endtask

  task automatic rand_fill();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) tA[i][k] = 8'($urandom);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 2; j++) tB[k][j] = 8'($urandom);
  endtask

  task automatic job(input int g, input bit presend, input bit gap12,
                     input bit rgaps, input bit noise, input bit hold,
                     input bit abort, input string tag);
    int  kd, n, lat, ng;
    bit  ok;
    kd = (g == 0) ? 4 : 2;
    if (!presend) begin
      @(posedge clk); #2;
      drive_idle(g, 1'b1);
    end
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 10) begin
      @(posedge clk); #2;
      n++;
      ok = (g == 0) ? rdy0 : rdy1;
    end
    chk({tag, "_ready"}, ok, 1);
    drive_idle(g, 1'b0);
    for (int k = 0; k < kd; k++) begin
      if (gap12) ng = (k == 2) ? 2 : 0;
      else if (rgaps) ng = $urandom_range(0, 2);
      else ng = 0;
      repeat (ng) begin
        drive_idle(g, noise && ($urandom_range(0, 2) == 0));
        @(posedge clk); #2;
      end
      drive(g, noise && ($urandom_range(0, 2) == 0), 1'b1,
            tA[0][k], tA[1][k], tB[k][0], tB[k][1]);
      @(posedge clk); #2;
    end
    drive_idle(g, hold);
    if (abort) begin
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      repeat (4) begin
        @(negedge clk);
        chk({tag, "_no_done"}, done0, 0);
      end
      chk({tag, "_busy"}, busy0, 0);
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          chk({tag, "_c_zero"}, c0[i][j], 0);
    end else begin
      lat = 0;
      ok  = 1'b0;
      while (!ok && lat < 10) begin
        @(negedge clk);
        lat++;
        ok = (g == 0) ? done0 : done1;
      end
      chk({tag, "_latency"}, lat, 3);
    end
  endtask

  task automatic set_d1();
    tA = '{'{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd5, 8'd6, 8'd7, 8'd8}};
    tB = '{'{8'd1, 8'd0}, '{8'd0, 8'd1}, '{8'd1, 8'd1}, '{8'd2, 8'd3}};
  endtask

  task automatic chk_d1(input string tag);
    chk({tag, "_c00"}, c0[0][0], 12);
    chk({tag, "_c01"}, c0[0][1], 17);
    chk({tag, "_c10"}, c0[1][0], 28);
    chk({tag, "_c11"}, c0[1][1], 37);
  endtask

  initial begin
    bit hold;
    int g;
    drive(0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy0, 0);
    chk("reset_ready", rdy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_c", c0[1][1], 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    set_d1();
    job(0, 0, 0, 0, 0, 0, 0, "contig");
    chk_d1("contig");
    job(0, 0, 1, 0, 0, 0, 0, "stall");
    chk_d1("stall");

    rand_fill();
    job(0, 0, 0, 0, 1, 1, 0, "b2b_first");
    set_d1();
    job(0, 1, 0, 0, 1, 0, 0, "b2b_second");
    chk_d1("b2b_second");

    tA[0][0] = 8'h80; tA[0][1] = 8'h7F;
    tA[1][0] = 8'hFF; tA[1][1] = 8'h01;
    tB[0][0] = 8'h80; tB[0][1] = 8'h01;
    tB[1][0] = 8'h01; tB[1][1] = 8'hFF;
    job(1, 0, 0, 0, 0, 0, 0, "signed");
    chk("signed_c00", c1[0][0], 20'd16511);
    chk("signed_c01", c1[0][1], 20'd1048321);
    chk("signed_c10", c1[1][0], 20'd129);
    chk("signed_c11", c1[1][1], 20'd1048574);

    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        tA[i][k] = 8'hFF;
        tB[k][i] = 8'hFF;
      end
    job(1, 0, 0, 0, 0, 0, 0, "wrap");
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        chk("wrap_c", c2[i][j], 16'd64514);

    rand_fill();
    job(0, 0, 0, 1, 1, 0, 1, "abort");
    set_d1();
    job(0, 0, 0, 0, 0, 0, 0, "after_abort");
    chk_d1("after_abort");

    for (int n = 0; n < 16; n++) begin
      g = n % 2;
      hold = ($urandom_range(0, 2) == 0);
      rand_fill();
      job(g, 0, 0, 1, 1, hold, 0, "rnd");
      if (hold) begin
        rand_fill();
        job(g, 1, 0, 1, 1, 0, 0, "rnd_b2b");
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
